// File: rtl/ahb_busmatrix_pkg.sv
// rtl/ahb_busmatrix_pkg.sv - shared AHB-Lite encodings and burst helpers for the bus matrix
package ahb_busmatrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam int REM_W = 5;

  function automatic logic [REM_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_beat_counter.sv
// rtl/ahb_burst_beat_counter.sv - remaining-beat counter for fixed-length AHB bursts
module ahb_burst_beat_counter
  import ahb_busmatrix_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  output logic       hold_o
);

  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;
  logic             fixed_burst;

  assign fixed_burst = (hburst_i != HBURST_SINGLE) && (hburst_i != HBURST_INCR);

  always_comb begin
    rem_d = rem_q;
    case (htrans_i)
      HTRANS_NONSEQ: rem_d = fixed_burst ? (burst_len(hburst_i) - 5'd1) : '0;
      HTRANS_SEQ:    rem_d = (rem_q == '0) ? '0 : (rem_q - 5'd1);
      HTRANS_IDLE:   rem_d = '0;
      default:       rem_d = rem_q;
    endcase
  end

  // Hold is judged on the post-update count so the last beat releases the grant.
  assign hold_o = (rem_d != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
    end else if (en_i) begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// rtl/ahblite_busmatrix_arbiter_rr.sv - burst-aware round-robin output-stage arbiter (option: AHB_ARB_MASTLOCK_EN)
module ahblite_busmatrix_arbiter_rr
  import ahb_busmatrix_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] REQ,
  input  logic                 HREADY_Outputstage,
  input  logic                 HSEL_Outputstage,
  input  logic [1:0]           HTRANS_Outputstage,
  input  logic [2:0]           HBURST_Outputstage,
`ifdef AHB_ARB_MASTLOCK_EN
  input  logic                 HMASTLOCK_Outputstage,
`endif
  output logic [PORT_W-1:0]    PORT_SEL,
  output logic                 PORT_NOSEL,
  output logic [NUM_PORTS-1:0] GRANT
);

  localparam logic [PORT_W:0]   NP_W = (PORT_W+1)'(NUM_PORTS);
  localparam logic [PORT_W-1:0] LAST = PORT_W'(NUM_PORTS-1);

  logic [PORT_W-1:0]      sel_q, sel_d;
  logic                   nosel_q, nosel_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [PORT_W-1:0]      ptr_q, ptr_d;

  logic                   burst_hold;
  logic                   incr_hold;
  logic                   lock_hold;
  logic                   hold;

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic                   found;
  logic [PORT_W-1:0]      off;
  logic [PORT_W:0]        sum;
  logic [PORT_W-1:0]      winner;

  ahb_burst_beat_counter u_beat_cnt (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .en_i     (HREADY_Outputstage),
    .htrans_i (HTRANS_Outputstage),
    .hburst_i (HBURST_Outputstage),
    .hold_o   (burst_hold)
  );

`ifdef AHB_ARB_MASTLOCK_EN
  logic lock_q;

  // A locked transfer keeps ownership through the following accepted transfer too.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_q <= 1'b0;
    end else if (HREADY_Outputstage) begin
      lock_q <= HMASTLOCK_Outputstage;
    end
  end

  assign lock_hold = HMASTLOCK_Outputstage | lock_q;
`else
  assign lock_hold = 1'b0;
`endif

  // Undefined-length INCR keeps the owner only while it is still requesting.
  assign incr_hold = (HBURST_Outputstage == HBURST_INCR) &&
                     (HTRANS_Outputstage != HTRANS_IDLE) &&
                     !nosel_q && REQ[sel_q];

  assign hold = burst_hold | incr_hold | lock_hold;

  // Rotate requests so bit 0 is the port at ptr; lowest set bit is the winner.
  assign req_dbl = {REQ, REQ};
  assign req_rot = req_dbl[ptr_q +: NUM_PORTS];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = PORT_W'(i);
      end
    end
  end

  assign sum    = {1'b0, ptr_q} + {1'b0, off};
  assign winner = (sum >= NP_W) ? PORT_W'(sum - NP_W) : sum[PORT_W-1:0];

  always_comb begin
    sel_d   = sel_q;
    nosel_d = nosel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!hold) begin
      if (found) begin
        sel_d   = winner;
        nosel_d = 1'b0;
        grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner;
        ptr_d   = (winner == LAST) ? '0 : (winner + 1'b1);
      end else if (!HSEL_Outputstage) begin
        nosel_d = 1'b1;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q   <= '0;
      nosel_q <= 1'b1;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (HREADY_Outputstage) begin
      sel_q   <= sel_d;
      nosel_q <= nosel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign PORT_SEL   = sel_q;
  assign PORT_NOSEL = nosel_q;
  assign GRANT      = grant_q;

endmodule

// File: doc/ahblite_busmatrix_arbiter_rr.md
Name: ahblite_busmatrix_arbiter_rr

Overview:
- Parametrised round-robin arbiter for one bus-matrix output stage. It serves NUM_PORTS input-stage requesters.
- Generalises the single-requester arbiter to N requesters, with fair rotation and burst-aware grant holding.
- Sits between the input stages' REQ lines and the output-stage address/data mux. It drives registered port-select and no-port signals.
- Grant updates only on edges where the output stage is ready, so the data-phase mux select stays stable.

Parameters:
- NUM_PORTS, 4: number of requesting input stages, 2..8.
- PORT_W, 2: select width, must equal ceil(log2(NUM_PORTS)), minimum 1.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- REQ  input  NUM_PORTS  per-input-stage request, bit i = port i.
- HREADY_Outputstage  input  1  output-stage HREADY; gates all state updates.
- HSEL_Outputstage  input  1  slave selected by current owner's address phase.
- HTRANS_Outputstage  input  2  current address-phase HTRANS.
- HBURST_Outputstage  input  3  current address-phase HBURST.
- PORT_SEL  output  PORT_W  registered index of granted port.
- PORT_NOSEL  output  1  registered; 1 means no port owns the stage.
- GRANT  output  NUM_PORTS  registered one-hot of PORT_SEL, all-zero when PORT_NOSEL=1.

Behaviour:
- Clocking and reset:
  - Single clock, HCLK. Asynchronous active-low reset, HRESETn.
  - Reset values: PORT_NOSEL=1, PORT_SEL=0, GRANT=0, rr pointer=0, beat counter rem=0.
- Update gating:
  - All registers update only on a HCLK rising edge with HREADY_Outputstage=1.
  - With HREADY_Outputstage=0, every register holds. This includes mid-burst wait states.
- Beat counter rem (5 bits), updated on accepted edges:
  - NONSEQ with fixed burst: rem = len-1. INCR4/WRAP4 len=4, INCR8/WRAP8 len=8, INCR16/WRAP16 len=16.
  - NONSEQ with SINGLE or INCR: rem = 0.
  - SEQ: rem = rem-1, saturating at 0.
  - IDLE (early termination): rem = 0.
  - BUSY: rem unchanged.
- Hold condition, evaluated with rem_next:
  - hold when rem_next != 0, OR
  - hold when HBURST=INCR, HTRANS is NONSEQ, SEQ or BUSY, PORT_NOSEL=0, and REQ[PORT_SEL]=1.
  - While hold is asserted, PORT_SEL, GRANT and PORT_NOSEL do not change.
- Arbitration, on an accepted edge without hold:
  - Search REQ starting at index ptr, wrapping modulo NUM_PORTS. The first set bit wins.
  - ptr advances to winner+1, wrapping to 0 after NUM_PORTS-1.
  - A winner sets PORT_NOSEL=0 and PORT_SEL=winner.
- No request:
  - If REQ==0 and HSEL_Outputstage=1, keep the current grant so the last data phase completes. PORT_NOSEL is unchanged.
  - If REQ==0 and HSEL_Outputstage=0, PORT_NOSEL=1. PORT_SEL retains its last value. ptr is unchanged.
- Latency:
  - A request is visible in PORT_SEL one accepted edge after REQ rises, when no hold is active.
- Simultaneous events: owner drops REQ while a fixed burst has rem_next != 0 → grant still held until rem reaches 0.
- Ignored inputs: REQ bits at index NUM_PORTS and above cannot exist. X on REQ while HREADY_Outputstage=0 is ignored.

Optional Feature:
- Macro: AHB_ARB_MASTLOCK_EN.
- With the macro defined:
  - Adds input HMASTLOCK_Outputstage (1 bit).
  - An accepted transfer with HMASTLOCK_Outputstage=1 forces hold on that edge and on the following accepted edge. This covers the transfer that releases the lock.
- Without the macro: the port is absent and no lock-based holding occurs.

Decomposition:
- Shared package ahb_busmatrix_pkg holds:
  - HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HBURST encodings: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - Function burst_len(hburst) returning 1/4/8/16.
- Sub-module ahb_burst_beat_counter: holds rem and produces rem_next and the fixed-burst hold term. It is reused by future arbiters.

Test Plan:
- Reset: assert HRESETn=0 mid-operation with REQ=4'b1111 → PORT_NOSEL=1, PORT_SEL=0, GRANT=0 immediately. After release, the first accepted edge grants port 0.
- Rotation: REQ=4'b1111, HTRANS=NONSEQ SINGLE every cycle, HREADY=1 → PORT_SEL sequence 0,1,2,3,0.
- Fixed burst hold: port 1 issues INCR4 (NONSEQ+3 SEQ) with REQ=4'b1111 → PORT_SEL=1 for all 4 beats. Port 2 is granted on the edge accepting beat 4.
- Wait states: HREADY=0 for 3 cycles during a WRAP8 while REQ changes → no output changes. Counting resumes with rem intact.
- No-port: REQ=0 with HSEL=1 → grant held; next edge with HSEL=0 → PORT_NOSEL=1, PORT_SEL unchanged.
- Early termination: INCR8 owner drives IDLE after beat 3 → rem=0, re-arbitration on that edge.
